// File: rtl/mem_stage_wb.sv
// mem_stage_wb: memory-stage access controller and MEM/WB pipeline register.
// Launches one registered valid/ack data-memory access per load/store, stalls
// the upstream stages while it is outstanding, and feeds the write-back stage.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   RegWriteM..WriteRegM  EX/MEM register outputs (held by upstream while StallM)
//   StallM                combinational stall to IF/ID/EX/MEM
//   dmem_req/we/addr/wdata registered memory request; dmem_rdata/dmem_ack response
//   bus_err               sticky bus-timeout flag
//   RegWriteW..WriteRegW  MEM/WB register outputs
//
// Optional feature: define DMEM_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT_CYCLES cycles without ack (rdata forced to 32'hDEADBEEF, bus_err set).
module mem_stage_wb #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        StallM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        bus_err,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    logic [1:0]  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdq_q, rdq_d;
    logic        err_q, err_d;
    logic        rw_w_q, rw_w_d;
    logic        m2r_w_q, m2r_w_d;
    logic [31:0] rd_w_q, rd_w_d;
    logic [31:0] alu_w_q, alu_w_d;
    logic [4:0]  wr_w_q, wr_w_d;
    logic        stall_c;
    logic        access;

    assign access = MemtoRegM | MemWriteM;

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdq_q   <= '0;
            err_q   <= 1'b0;
            rw_w_q  <= 1'b0;
            m2r_w_q <= 1'b0;
            rd_w_q  <= '0;
            alu_w_q <= '0;
            wr_w_q  <= '0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdq_q   <= rdq_d;
            err_q   <= err_d;
            rw_w_q  <= rw_w_d;
            m2r_w_q <= m2r_w_d;
            rd_w_q  <= rd_w_d;
            alu_w_q <= alu_w_d;
            wr_w_q  <= wr_w_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state, bus request and MEM/WB load; W defaults to a bubble
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdq_d   = rdq_q;
        err_d   = err_q;
        rw_w_d  = 1'b0;
        m2r_w_d = 1'b0;
        rd_w_d  = '0;
        alu_w_d = '0;
        wr_w_d  = '0;
        stall_c = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    stall_c = 1'b1;
                    req_d   = 1'b1;
                    // load wins when both load and store are flagged
                    we_d    = MemWriteM & ~MemtoRegM;
                    addr_d  = ALUOutM;
                    wdata_d = WriteDataM;
                    state_d = BUSY;
`ifdef DMEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    rw_w_d  = RegWriteM;
                    m2r_w_d = MemtoRegM;
                    alu_w_d = ALUOutM;
                    wr_w_d  = WriteRegM;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (dmem_ack) begin
                    rdq_d   = we_q ? 32'h0 : dmem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdq_d   = 32'hDEADBEEF;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                rw_w_d  = RegWriteM;
                m2r_w_d = MemtoRegM;
                rd_w_d  = rdq_q;
                alu_w_d = ALUOutM;
                wr_w_d  = WriteRegM;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign StallM     = stall_c;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign bus_err    = err_q;
    assign RegWriteW  = rw_w_q;
    assign MemtoRegW  = m2r_w_q;
    assign ReadDataW  = rd_w_q;
    assign ALUOutW    = alu_w_q;
    assign WriteRegW  = wr_w_q;

endmodule

// File: tb/tb_mem_stage_wb.sv
module tb_mem_stage_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        StallM, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack, bus_err;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0]  WriteRegW;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected write-back contents (transaction-level model)
    logic        e_rw, e_m2r, e_err;
    logic [31:0] e_rd, e_alu;
    logic [4:0]  e_wr;

    always #5 clk = ~clk;

    mem_stage_wb #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .bus_err(bus_err),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
        .ALUOutW(ALUOutW), .WriteRegW(WriteRegW)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag);
        check({tag, ".RegWriteW"}, 32'(RegWriteW), 32'(e_rw));
        check({tag, ".MemtoRegW"}, 32'(MemtoRegW), 32'(e_m2r));
        check({tag, ".ReadDataW"}, ReadDataW, e_rd);
        check({tag, ".ALUOutW"},   ALUOutW, e_alu);
        check({tag, ".WriteRegW"}, 32'(WriteRegW), 32'(e_wr));
        check({tag, ".bus_err"},   32'(bus_err), 32'(e_err));
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".RegWriteW"}, 32'(RegWriteW), 32'h0);
        check({tag, ".MemtoRegW"}, 32'(MemtoRegW), 32'h0);
    endtask

    task automatic set_zero_w();
        e_rw = 1'b0; e_m2r = 1'b0; e_rd = '0; e_alu = '0; e_wr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One instruction through MEM; d = BUSY cycles, ack in the last (d>=1).
    // Called at a negedge; returns at the negedge where its write-back is visible.
    task automatic run_op(input string tag, input logic rw, input logic mr, input logic mw,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] wr, input int d, input logic [31:0] rd);
        logic acc;
        logic exp_we;
        acc    = mr | mw;
        exp_we = mw & ~mr;
        check_w({tag, ".prev"});
        RegWriteM = rw; MemtoRegM = mr; MemWriteM = mw;
        ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
        #1;
        check({tag, ".stall_idle"}, 32'(StallM), 32'(acc));
        check({tag, ".req_idle"}, 32'(dmem_req), 32'h0);
        next_cycle();
        if (acc) begin
            for (int i = 1; i <= d; i++) begin
                check({tag, ".req_busy"}, 32'(dmem_req), 32'h1);
                check({tag, ".we"}, 32'(dmem_we), 32'(exp_we));
                check({tag, ".addr"}, dmem_addr, alu);
                check({tag, ".wdata"}, dmem_wdata, wd);
                check({tag, ".stall_busy"}, 32'(StallM), 32'h1);
                check_bubble({tag, ".busy"});
                dmem_ack   = (i == d);
                dmem_rdata = (i == d) ? rd : $urandom;
                next_cycle();
                dmem_ack   = 1'b0;
                dmem_rdata = $urandom;
            end
            check({tag, ".stall_done"}, 32'(StallM), 32'h0);
            check({tag, ".req_done"}, 32'(dmem_req), 32'h0);
            check_bubble({tag, ".done"});
            next_cycle();
        end
        e_rw = rw; e_m2r = mr; e_alu = alu; e_wr = wr;
        e_rd = mr ? rd : 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        set_zero_w();
        e_err = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
        ALUOutM = '0; WriteDataM = '0; WriteRegM = '0;
        dmem_ack = 0; dmem_rdata = '0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst.req", 32'(dmem_req), 32'h0);
        check("rst.we", 32'(dmem_we), 32'h0);
        check("rst.addr", dmem_addr, 32'h0);
        check("rst.wdata", dmem_wdata, 32'h0);
        check("rst.stall", 32'(StallM), 32'h0);

        // Directed: ALU op, load, store, back-to-back load/store
        run_op("alu", 1, 0, 0, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
        run_op("load", 1, 1, 0, 32'h100, 32'h0, 5'd7, 2, 32'hCAFEF00D);
        run_op("store", 0, 0, 1, 32'h40, 32'hA5A5A5A5, 5'd0, 1, 32'h0);
        run_op("b2b_ld", 1, 1, 0, 32'h200, 32'h0, 5'd9, 1, 32'h12345678);
        run_op("b2b_st", 0, 0, 1, 32'h204, 32'h5A5A0F0F, 5'd0, 3, 32'hFFFF0000);
        run_op("both", 1, 1, 1, 32'h300, 32'h77, 5'd3, 2, 32'h0BADF00D);
        run_op("alu2", 1, 0, 0, 32'hFFFFFFFF, 32'h0, 5'd31, 0, 32'h0);

        // Reset while BUSY, then stray ack after reset
        check_w("rstbusy.prev");
        RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0;
        ALUOutM = 32'h500; WriteRegM = 5'd4;
        next_cycle();
        check("rstbusy.req_before", 32'(dmem_req), 32'h1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
        ALUOutM = '0; WriteDataM = '0; WriteRegM = '0;
        dmem_ack = 1'b1; dmem_rdata = 32'h99999999;
        #1;
        set_zero_w();
        e_err = 1'b0;
        check("rstbusy.req", 32'(dmem_req), 32'h0);
        check("rstbusy.addr", dmem_addr, 32'h0);
        check("rstbusy.stall", 32'(StallM), 32'h0);
        check_w("rstbusy.w");
        next_cycle();
        dmem_ack = 1'b0;
        check("stray.req", 32'(dmem_req), 32'h0);
        check("stray.stall", 32'(StallM), 32'h0);
        check_w("stray.w");
        run_op("post_rst_alu", 1, 0, 0, 32'hABCD, 32'h0, 5'd2, 0, 32'h0);

        // Randomized instruction mix
        for (int n = 0; n < 24; n++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            run_op("rand", 1'($urandom), kind == 1 || kind == 3, kind == 2 || kind == 3,
                   $urandom, $urandom, 5'($urandom), int'($urandom_range(1, 4)), $urandom);
        end

`ifdef DMEM_TIMEOUT_EN
        // Ack arriving on the expiry cycle wins
        run_op("ack_at_expiry", 1, 1, 0, 32'h600, 32'h0, 5'd6, 4, 32'h13579BDF);
        // No ack: timeout after 4 BUSY cycles
        check_w("tmo.prev");
        RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0;
        ALUOutM = 32'h700; WriteRegM = 5'd8;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            check("tmo.req_busy", 32'(dmem_req), 32'h1);
            check("tmo.err_busy", 32'(bus_err), 32'h0);
            next_cycle();
        end
        check("tmo.req_drop", 32'(dmem_req), 32'h0);
        check("tmo.err_set", 32'(bus_err), 32'h1);
        next_cycle();
        e_rw = 1; e_m2r = 1; e_rd = 32'hDEADBEEF; e_alu = 32'h700; e_wr = 5'd8;
        e_err = 1'b1;
        run_op("tmo.sticky", 1, 1, 0, 32'h704, 32'h0, 5'd9, 1, 32'h2468ACE0);
        check_w("tmo.after");
        do_reset();
        check("tmo.err_reset", 32'(bus_err), 32'h0);
`endif

        check_w("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
